// File: rtl/switch_debounce_fsm.sv
// Switch conditioner: input synchroniser, free-running sample tick, and an 8-state
// debounce FSM that produces a registered debounced level and a rising-edge tick.
module switch_debounce_fsm #(
    parameter int N           = 19,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic sw_in,
    output logic db_level,
    output logic db_tick
);

    localparam logic [2:0] ZERO    = 3'd0;
    localparam logic [2:0] WAIT1_1 = 3'd1;
    localparam logic [2:0] WAIT1_2 = 3'd2;
    localparam logic [2:0] WAIT1_3 = 3'd3;
    localparam logic [2:0] ONE     = 3'd4;
    localparam logic [2:0] WAIT0_1 = 3'd5;
    localparam logic [2:0] WAIT0_2 = 3'd6;
    localparam logic [2:0] WAIT0_3 = 3'd7;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sw_s;
    logic [N-1:0]           cnt;
    logic                   m_tick;
    logic [2:0]             state;
    logic [2:0]             next_state;
    logic                   level_next;
    logic                   tick_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sw_in};
        end
    end

    assign sw_s = sync_q[SYNC_STAGES-1];

    // Sample-period timer runs independently of the FSM so the tick phase never slips.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign m_tick = (cnt == '0);

    always_comb begin
        next_state = state;
        case (state)
            ZERO:    if (sw_s)   next_state = WAIT1_1;
            WAIT1_1: if (!sw_s)  next_state = ZERO;
                     else if (m_tick) next_state = WAIT1_2;
            WAIT1_2: if (!sw_s)  next_state = ZERO;
                     else if (m_tick) next_state = WAIT1_3;
            WAIT1_3: if (!sw_s)  next_state = ZERO;
                     else if (m_tick) next_state = ONE;
            ONE:     if (!sw_s)  next_state = WAIT0_1;
            WAIT0_1: if (sw_s)   next_state = ONE;
                     else if (m_tick) next_state = WAIT0_2;
            WAIT0_2: if (sw_s)   next_state = ONE;
                     else if (m_tick) next_state = WAIT0_3;
            WAIT0_3: if (sw_s)   next_state = ONE;
                     else if (m_tick) next_state = ZERO;
            default: next_state = ZERO;
        endcase
    end

    // Outputs are decoded from next_state so the registered values line up with state.
    always_comb begin
        level_next = (next_state == ONE)     || (next_state == WAIT0_1) ||
                     (next_state == WAIT0_2) || (next_state == WAIT0_3);
        tick_next  = (state == WAIT1_3) && (next_state == ONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ZERO;
            db_level <= 1'b0;
            db_tick  <= 1'b0;
        end else begin
            state    <= next_state;
            db_level <= level_next;
            db_tick  <= tick_next;
        end
    end

endmodule

// File: tb/tb_switch_debounce_fsm.sv
// Directed bench for switch_debounce_fsm with N=3 (sample tick every 8 clk).
module tb_switch_debounce_fsm;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sw_in = 1'b0;
    logic db_level;
    logic db_tick;

    int vectors = 0;
    int miscompares = 0;
    int edges = 0;
    int tick_count = 0;
    int tick_edge = -1;

    switch_debounce_fsm #(.N(3), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .sw_in    (sw_in),
        .db_level (db_level),
        .db_tick  (db_tick)
    );

    always #5 clk = ~clk;

    // Edge count since reset release: before edge e the counter holds (e-1) mod 8.
    always @(posedge clk or posedge reset) begin
        if (reset) edges <= 0;
        else       edges <= edges + 1;
    end

    always @(posedge clk) begin
        #1;
        if (db_tick === 1'b1) begin
            tick_count++;
            tick_edge = edges;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Third sample tick strictly after the edge that entered a WAIT state.
    function automatic int third_tick(input int enter);
        int n;
        n = 0;
        for (int e = enter + 1; e < enter + 40; e++) begin
            if (((e - 1) % 8) == 0) begin
                n++;
                if (n == 3) return e;
            end
        end
        return -1;
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic go_to_phase(input int p);
        while ((edges % 8) != p) @(negedge clk);
    endtask

    task automatic wait_for_level(input logic lvl, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (db_level === lvl) begin
                at = edges;
                break;
            end
        end
    endtask

    int j, jr, exp_edge, at, t0, hi;

    initial begin
        step(3);
        check("reset_level", db_level, 0);
        check("reset_tick", db_tick, 0);
        check("reset_state", dut.state, 0);
        reset = 1'b0;

        // Clean press, entry phase chosen so WAIT1_1 is entered just after a tick.
        go_to_phase(7);
        j = edges;
        t0 = tick_count;
        sw_in = 1'b1;
        exp_edge = third_tick(j + 3);
        wait_for_level(1'b1, 40, at);
        check("press_rise_edge", at, exp_edge);
        check("press_rise_delay", at - j, 26);
        step(10);
        check("press_hold_level", db_level, 1);
        check("press_tick_count", tick_count - t0, 1);
        check("press_tick_edge", tick_edge, exp_edge);

        // Clean release: falls after three ticks, no pulse.
        go_to_phase(7);
        j = edges;
        t0 = tick_count;
        sw_in = 1'b0;
        exp_edge = third_tick(j + 3);
        wait_for_level(1'b0, 40, at);
        check("release_fall_edge", at, exp_edge);
        step(5);
        check("release_no_tick", tick_count - t0, 0);

        // Short high glitch never promotes.
        t0 = tick_count;
        hi = 0;
        sw_in = 1'b1;
        for (int i = 0; i < 10; i++) begin @(negedge clk); if (db_level !== 1'b0) hi = 1; end
        sw_in = 1'b0;
        for (int i = 0; i < 30; i++) begin @(negedge clk); if (db_level !== 1'b0) hi = 1; end
        check("glitch_level_high", hi, 0);
        check("glitch_tick_count", tick_count - t0, 0);

        // Bounce: 5 periods of 3 high / 3 low, then settle high.
        t0 = tick_count;
        hi = 0;
        for (int k = 0; k < 5; k++) begin
            sw_in = 1'b1;
            for (int i = 0; i < 3; i++) begin @(negedge clk); if (db_level !== 1'b0) hi = 1; end
            sw_in = 1'b0;
            for (int i = 0; i < 3; i++) begin @(negedge clk); if (db_level !== 1'b0) hi = 1; end
        end
        check("bounce_level_high", hi, 0);
        j = edges;
        sw_in = 1'b1;
        exp_edge = third_tick(j + 3);
        wait_for_level(1'b1, 40, at);
        check("bounce_rise_edge", at, exp_edge);
        step(20);
        check("bounce_tick_count", tick_count - t0, 1);
        check("bounce_tick_edge", tick_edge, exp_edge);

        // Release with a 5-clk high glitch during WAIT0_2 restarts the fall wait.
        go_to_phase(7);
        jr = edges;
        t0 = tick_count;
        sw_in = 1'b0;
        step(12);
        check("rel_glitch_wait0_2", dut.state, 6);
        sw_in = 1'b1;
        step(5);
        check("rel_glitch_back_one", dut.state, 4);
        sw_in = 1'b0;
        j = edges;
        exp_edge = third_tick(j + 3);
        wait_for_level(1'b0, 50, at);
        check("rel_glitch_fall_edge", at, exp_edge);
        check("rel_glitch_fall_delay", at - jr, 42);
        check("rel_glitch_no_tick", tick_count - t0, 0);
        step(4);

        // sw_s drop coinciding with the promoting tick in WAIT1_3 must win.
        go_to_phase(7);
        j = edges;
        t0 = tick_count;
        sw_in = 1'b1;
        step(23);
        sw_in = 1'b0;
        step(2);
        check("prio_in_wait1_3", dut.state, 3);
        step(1);
        check("prio_state_zero", dut.state, 0);
        check("prio_level", db_level, 0);
        step(10);
        check("prio_no_tick", tick_count - t0, 0);
        check("prio_level_later", db_level, 0);

        // Async reset mid-WAIT1_2, then recover with input held high.
        go_to_phase(7);
        sw_in = 1'b1;
        step(12);
        check("rst_in_wait1_2", dut.state, 2);
        reset = 1'b1;
        #1;
        check("rst_async_state", dut.state, 0);
        check("rst_async_level", db_level, 0);
        check("rst_async_tick", db_tick, 0);
        @(negedge clk);
        t0 = tick_count;
        reset = 1'b0;
        wait_for_level(1'b1, 30, at);
        check("rst_recover_edge", at, 25);
        step(3);
        check("rst_recover_tick", tick_count - t0, 1);
        check("rst_recover_tick_edge", tick_edge, 25);

        // Reset in ONE clears the level without waiting for a clock.
        reset = 1'b1;
        #1;
        check("rst_from_one_level", db_level, 0);
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
